instruction_mem_sync: RTL and testbench
=======================================

Name: instruction_mem_sync

Overview:
Parametrised, synchronous successor to the CPU's combinational instruction ROM. It holds DEPTH words of RAM that a streaming loader port fills at run time, so no program is hard-coded. It serves registered instruction fetches to the IF stage with one-cycle latency and stall-hold. Misaligned and out-of-range fetches are flagged as faults and answered with a NOP.

Parameters:
ADDR_WIDTH, 32, width of the fetch byte address.
DATA_WIDTH, 32, instruction/word width.
DEPTH, 64, number of words; power of 2, at least 2; IDX_W = log2(DEPTH).
NOP_INSTR, 32'h00000013, word driven on fault or when no word is available (addi x0,x0,0).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_prog_start  input  1  pulse: clear the write pointer and enter LOAD.
i_prog_valid  input  1  loader word valid.
i_prog_wdata  input  DATA_WIDTH  loader word.
i_prog_last  input  1  marks the final word of the image; qualified by i_prog_valid.
o_prog_ready  output  1  high in LOAD; a word is accepted when i_prog_valid && o_prog_ready.
o_prog_count  output  IDX_W+1  number of words written since the last i_prog_start.
o_loaded  output  1  high in RUN.
i_req  input  1  fetch request.
i_addr  input  ADDR_WIDTH  fetch byte address.
i_stall  input  1  pipeline stall; hold the current fetch result.
o_instr  output  DATA_WIDTH  fetched instruction.
o_valid  output  1  o_instr/o_fault are valid.
o_fault  output  1  the fetch was misaligned or out of range.

Behaviour:
- Reset (asynchronous, any time, including mid-load or mid-fetch):
  - state=EMPTY, write pointer=0, o_prog_count=0.
  - o_valid=0, o_fault=0, o_instr=NOP_INSTR, o_prog_ready=0, o_loaded=0.
  - RAM contents are not cleared and are not guaranteed after reset.
- State machine EMPTY / LOAD / RUN:
  - EMPTY -> LOAD on i_prog_start.
  - LOAD -> RUN on an accepted word that has i_prog_last=1 or is written at pointer DEPTH-1.
  - RUN -> LOAD on i_prog_start (reprogram).
  - i_prog_start in LOAD restarts the load: pointer=0, count=0.
  - i_prog_start has priority over a same-cycle accepted word; that word is dropped.
- Loader:
  - An accepted word writes RAM[ptr], then ptr++ and count++.
  - The pointer never wraps, because the block leaves LOAD at DEPTH-1.
  - i_prog_valid outside LOAD is ignored.
- Fetch, in RUN with i_stall=0:
  - i_req is sampled at the edge; on the next cycle o_valid=1.
  - Aligned (i_addr[1:0]==0) and in range (i_addr < DEPTH*4, all upper bits zero): o_instr=RAM[i_addr[IDX_W+1:2]], o_fault=0.
  - Otherwise: o_instr=NOP_INSTR, o_fault=1.
  - i_req=0: o_valid=0 next cycle; o_instr keeps its last value.
- Stall: with i_stall=1, o_instr, o_valid and o_fault hold; i_req is ignored, and the requester must re-present the address after the stall.
- Not in RUN: i_req is ignored; o_valid=0 and o_fault=0 on the next cycle.
- i_prog_start while o_valid=1: o_valid=0 next cycle, regardless of i_stall.
- Throughput: one fetch per cycle, back-to-back, with no bubbles.

Test Plan:
- Reset, i_prog_start, stream 32'h00000537, 32'h05056593, 32'h00500613 with last on word 3 -> o_prog_count=3, o_loaded=1; fetches at 0x0, 0x4, 0x8 in consecutive cycles return those words, each one cycle after its request.
- Fetch 0x6 -> o_fault=1, o_instr=32'h00000013; fetch DEPTH*4 (0x100) -> o_fault=1; fetch 0xFC (word 63 of an unwritten slot) -> o_fault=0.
- Stream 64 words with i_prog_last=0 -> automatic transition to RUN after the 64th word; o_prog_count=64; a 65th i_prog_valid is ignored.
- Fetch 0x4, then hold i_stall=1 for 3 cycles while i_addr changes to 0x8 -> o_instr stays 32'h05056593 with o_valid=1; after the stall is released, a re-presented 0x8 returns 32'h00500613.
- Assert i_rst asynchronously mid-load (after 2 words) -> outputs take reset values immediately; i_req is ignored (o_valid=0) until a new load completes.
- In RUN, assert i_prog_start together with an i_req -> o_valid=0 next cycle, o_prog_ready=1, o_prog_count=0; reload a single word 32'h0000006f with last -> fetch 0x0 returns 32'h0000006f.

Source files
------------

// File: rtl/instruction_mem_sync.sv
// Run-time loadable instruction RAM with registered, stall-holding fetch port.
// Fetch latency 1 cycle; loader is ready only while loading, and fetch holds its result under i_stall.
module instruction_mem_sync #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_prog_start,
  input  logic                      i_prog_valid,
  input  logic [DATA_WIDTH-1:0]     i_prog_wdata,
  input  logic                      i_prog_last,
  output logic                      o_prog_ready,
  output logic [$clog2(DEPTH):0]    o_prog_count,
  output logic                      o_loaded,
  input  logic                      i_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic                      i_stall,
  output logic [DATA_WIDTH-1:0]     o_instr,
  output logic                      o_valid,
  output logic                      o_fault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W:0]        count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      wr_ptr;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_en;
  logic                  addr_ok;

  // The word counter doubles as the write pointer; it never exceeds DEPTH.
  assign wr_ptr  = count_q[IDX_W-1:0];
  assign wr_en   = (state_q == S_LOAD) && i_prog_valid && !i_prog_start;
  assign rd_idx  = i_addr[IDX_W+1:2];
  assign addr_ok = (i_addr[1:0] == 2'b00) && ((i_addr >> (IDX_W + 2)) == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (i_prog_start) begin
      state_d = S_LOAD;
      count_d = '0;
    end else if (wr_en) begin
      count_d = count_q + CNT_ONE;
      if (i_prog_last || (&wr_ptr)) begin
        state_d = S_RUN;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    fault_d = fault_q;
    instr_d = instr_q;
    if (i_prog_start || (state_q != S_RUN)) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (!i_stall) begin
      if (i_req) begin
        valid_d = 1'b1;
        fault_d = !addr_ok;
        instr_d = addr_ok ? mem[rd_idx] : NOP_INSTR;
      end else begin
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_prog_wdata;
    end
  end

  assign o_prog_ready = (state_q == S_LOAD);
  assign o_loaded     = (state_q == S_RUN);
  assign o_prog_count = count_q;
  assign o_instr      = instr_q;
  assign o_valid      = valid_q;
  assign o_fault      = fault_q;

endmodule

// File: tb/tb_instruction_mem_sync.sv
// Directed bench for instruction_mem_sync: vector table for fetches plus load/reset/reprogram sequences.
module tb_instruction_mem_sync;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_start, prog_valid, prog_last;
  logic [31:0] prog_wdata;
  logic        prog_ready, loaded;
  logic [6:0]  prog_count;
  logic        req, stall;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        valid, fault;

  int checks = 0;
  int failures = 0;

  instruction_mem_sync dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_prog_start (prog_start),
    .i_prog_valid (prog_valid),
    .i_prog_wdata (prog_wdata),
    .i_prog_last  (prog_last),
    .o_prog_ready (prog_ready),
    .o_prog_count (prog_count),
    .o_loaded     (loaded),
    .i_req        (req),
    .i_addr       (addr),
    .i_stall      (stall),
    .o_instr      (instr),
    .o_valid      (valid),
    .o_fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        exp_valid;
    logic        exp_fault;
    logic        chk_instr;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    prog_valid = 1'b1;
    prog_wdata = w;
    prog_last  = last;
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req  = 1'b1;
    addr = a;
    step();
    req  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000537};
    vecs[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'h05056593};
    vecs[2]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500613};
    vecs[3]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b1, 1'b1, NOP};
    vecs[4]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1, NOP};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'h05056593};
    vecs[8]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h05056593};
    vecs[9]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h05056593};
    vecs[10] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h05056593};
    vecs[11] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500613};
    vecs[12] = '{1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500613};
    vecs[13] = '{1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b1, 1'b1, NOP};
    vecs[14] = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, NOP};
    vecs[15] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000537};

    rst = 1'b1;
    prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_wdata = '0;
    req = 1'b0; stall = 1'b0; addr = '0;
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_ready", 32'(prog_ready), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_count", 32'(prog_count), 32'd0);
    step();
    rst = 1'b0;

    // Fetch while EMPTY is ignored.
    fetch(32'h0);
    check("empty_valid", 32'(valid), 32'd0);

    start_load();
    check("load_ready", 32'(prog_ready), 32'd1);
    check("load_count0", 32'(prog_count), 32'd0);
    send_word(32'h00000537, 1'b0);
    send_word(32'h05056593, 1'b0);
    send_word(32'h00500613, 1'b1);
    check("prog3_count", 32'(prog_count), 32'd3);
    check("prog3_loaded", 32'(loaded), 32'd1);
    check("prog3_ready", 32'(prog_ready), 32'd0);

    for (int i = 0; i < 16; i++) begin
      req   = vecs[i].req;
      addr  = vecs[i].addr;
      stall = vecs[i].stall;
      step();
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      if (vecs[i].chk_instr) check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
    end
    req = 1'b0; stall = 1'b0;
    step();

    // Full-depth load ends LOAD automatically at the last slot.
    start_load();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("full63_loaded", 32'(loaded), 32'd0);
      send_word(32'hA000_0000 + 32'(i), 1'b0);
    end
    check("full_count", 32'(prog_count), 32'd64);
    check("full_loaded", 32'(loaded), 32'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    check("extra_count", 32'(prog_count), 32'd64);
    check("extra_loaded", 32'(loaded), 32'd1);
    fetch(32'h0000_00FC);
    check("full_w63", instr, 32'hA000_003F);
    check("full_w63_fault", 32'(fault), 32'd0);
    fetch(32'h0000_0000);
    check("full_w0", instr, 32'hA000_0000);
    check("full_w0_valid", 32'(valid), 32'd1);

    // Asynchronous reset in the middle of a load.
    start_load();
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_instr", instr, NOP);
    check("arst_count", 32'(prog_count), 32'd0);
    check("arst_ready", 32'(prog_ready), 32'd0);
    check("arst_loaded", 32'(loaded), 32'd0);
    step();
    rst = 1'b0;
    fetch(32'h0);
    check("arst_fetch_valid", 32'(valid), 32'd0);
    start_load();
    fetch(32'h0);
    check("arst_load_fetch_valid", 32'(valid), 32'd0);
    send_word(32'h3333_3333, 1'b1);
    check("arst_reload_loaded", 32'(loaded), 32'd1);
    fetch(32'h0);
    check("arst_reload_w0", instr, 32'h3333_3333);

    // Reprogram from RUN with a concurrent request and stall.
    req = 1'b1; addr = 32'h0; stall = 1'b1; prog_start = 1'b1;
    step();
    prog_start = 1'b0; req = 1'b0; stall = 1'b0;
    check("reprog_valid", 32'(valid), 32'd0);
    check("reprog_ready", 32'(prog_ready), 32'd1);
    check("reprog_count", 32'(prog_count), 32'd0);
    // Restart inside LOAD; the coincident word is dropped.
    send_word(32'h4444_4444, 1'b0);
    check("reprog_count1", 32'(prog_count), 32'd1);
    prog_start = 1'b1; prog_valid = 1'b1; prog_wdata = 32'hBAD0_BAD0; prog_last = 1'b1;
    step();
    prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    check("restart_count", 32'(prog_count), 32'd0);
    check("restart_loaded", 32'(loaded), 32'd0);
    send_word(32'h0000006f, 1'b1);
    check("reprog_final_count", 32'(prog_count), 32'd1);
    fetch(32'h0);
    check("reprog_w0", instr, 32'h0000006f);
    check("reprog_w0_valid", 32'(valid), 32'd1);
    step();
    check("idle_valid", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
